// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART parameter frame loader.
package loader_pkg;

   typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM} state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter between bytes of a frame; expired flags the last allowed cycle.
module frame_timer
   import loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Saturate at LAST so a power-of-two limit cannot wrap back to zero.
   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (en && cnt != LAST)
         cnt <= cnt + CW'(1);
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/uart_param_loader.sv
// Collects a sync-framed, checksummed byte stream into a shadow bank and
// commits it atomically onto the flat parameter bus.
module uart_param_loader
   import loader_pkg::*;
#(
   parameter int          NUM_WORDS      = 27,
   parameter int          WORD_BYTES     = 2,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [7:0]                        rx_data,
   input  logic                              rx_valid,
   output logic [NUM_WORDS*WORD_BYTES*8-1:0] params_out,
   output logic                              commit,
   output logic                              busy,
   output logic                              err_checksum,
   output logic                              err_timeout,
   output logic [7:0]                        frame_count
);

   localparam int N  = NUM_WORDS * WORD_BYTES;
   localparam int IW = cnt_width(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t            state, state_nx;
   logic [IW-1:0]     idx;
   logic [7:0]        sum;
   logic [N-1:0][7:0] shadow;
   logic              expired;
   logic              commit_nx, cs_err_nx, to_err_nx;

   frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (rx_valid || state == IDLE),
      .en      (state != IDLE),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // A byte in the same cycle as expiry wins over the timeout.
   always_comb begin
      state_nx  = state;
      commit_nx = 1'b0;
      cs_err_nx = 1'b0;
      to_err_nx = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) state_nx = PAYLOAD;
         end
         PAYLOAD: begin
            if (rx_valid) begin
               if (idx == LAST_IDX) state_nx = CSUM;
            end else if (expired) begin
               state_nx  = IDLE;
               to_err_nx = 1'b1;
            end
         end
         CSUM: begin
            if (rx_valid) begin
               state_nx = IDLE;
               if (rx_data == sum) commit_nx = 1'b1;
               else                cs_err_nx = 1'b1;
            end else if (expired) begin
               state_nx  = IDLE;
               to_err_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Index and sum are held clear while idle, so every sync starts a fresh frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx          <= '0;
         sum          <= '0;
         shadow       <= '0;
         params_out   <= '0;
         frame_count  <= '0;
         commit       <= 1'b0;
         busy         <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         commit       <= commit_nx;
         err_checksum <= cs_err_nx;
         err_timeout  <= to_err_nx;
         busy         <= (state_nx != IDLE);
         if (state == IDLE) begin
            idx <= '0;
            sum <= '0;
         end else if (state == PAYLOAD && rx_valid) begin
            shadow[idx] <= rx_data;
            sum         <= sum + rx_data;
            idx         <= idx + IW'(1);
         end
         if (commit_nx) begin
            params_out  <= shadow;
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule
